// File: rtl/pipeline_sequencer_if.sv
// Handshake bundle between the pipeline sequencer and the datapath buffers/multiplier.
// CNT_W must match the sequencer's CNT_W.
interface pipeline_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       ex_src_a;
    logic [3:0]       ex_src_b;
    logic             ex_is_mul;
    logic             ex_jump;
    logic [3:0]       wb_dest;
    logic             wb_has_wb;
    logic             mul_done;

    logic             pc_wr;
    logic             pc_sel_jump;
    logic             dec_exe_wr;
    logic             dec_exe_bubble;
    logic             exe_wb_wr;
    logic             exe_wb_bubble;
    logic             exe_wb_sel_mul;
    logic             rb_wr;
    logic             fwd_a;
    logic             fwd_b;
    logic             mul_start;
    logic             mul_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output ex_src_a, ex_src_b, ex_is_mul, ex_jump, wb_dest, wb_has_wb, mul_done,
        input  pc_wr, pc_sel_jump, dec_exe_wr, dec_exe_bubble, exe_wb_wr, exe_wb_bubble,
               exe_wb_sel_mul, rb_wr, fwd_a, fwd_b, mul_start, mul_err, stall_cnt
    );

    modport slave (
        input  ex_src_a, ex_src_b, ex_is_mul, ex_jump, wb_dest, wb_has_wb, mul_done,
        output pc_wr, pc_sel_jump, dec_exe_wr, dec_exe_bubble, exe_wb_wr, exe_wb_bubble,
               exe_wb_sel_mul, rb_wr, fwd_a, fwd_b, mul_start, mul_err, stall_cnt
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// Control FSM for the 3-stage 16-bit pipeline: write enables, jump bubbles,
// multiplier stall with watchdog, and writeback-to-execute forwarding.
//
// state | meaning
// BOOT  | first cycle after reset, instruction memory output not yet valid
// RUN   | normal flow, watches for multiply and taken jump
// MUL   | fetch frozen until mul_done or watchdog expiry
// FLUSH | one bubble for the instruction fetched before a redirect
module pipeline_sequencer #(
    parameter int MUL_MAX_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input logic                 CLK,
    input logic                 RST,
    pipeline_sequencer_if.slave seq
);
    localparam int MW = $clog2(MUL_MAX_CYCLES);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        MUL   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t           state;
    logic [MW-1:0]    mulCnt;
    logic             mulErr;
    logic [CNT_W-1:0] stallCnt;

    logic pcWr, pcSelJump, decExeWr, decExeBubble;
    logic exeWbWr, exeWbBubble, exeWbSelMul, mulStart;
    logic watchdogHit, stallInc;

    assign watchdogHit = (mulCnt == MW'(MUL_MAX_CYCLES - 1));

    always_comb begin
        pcWr         = 1'b0;
        pcSelJump    = 1'b0;
        decExeWr     = 1'b0;
        decExeBubble = 1'b0;
        exeWbWr      = 1'b0;
        exeWbBubble  = 1'b0;
        exeWbSelMul  = 1'b0;
        mulStart     = 1'b0;
        if (RST) begin
            case (state)
                BOOT, FLUSH: begin
                    pcWr         = 1'b1;
                    decExeWr     = 1'b1;
                    decExeBubble = 1'b1;
                    exeWbWr      = 1'b1;
                end
                RUN: begin
                    pcWr     = 1'b1;
                    decExeWr = 1'b1;
                    exeWbWr  = 1'b1;
                    if (seq.ex_is_mul) begin
                        // older instruction drains; the multiply itself waits for its result
                        mulStart    = 1'b1;
                        pcWr        = 1'b0;
                        decExeWr    = 1'b0;
                        exeWbBubble = 1'b1;
                    end else if (seq.ex_jump) begin
                        pcSelJump    = 1'b1;
                        decExeBubble = 1'b1;
                    end
                end
                MUL: begin
                    if (seq.mul_done) begin
                        exeWbWr     = 1'b1;
                        exeWbSelMul = 1'b1;
                        pcWr        = 1'b1;
                        decExeWr    = 1'b1;
                    end else if (watchdogHit) begin
                        exeWbWr     = 1'b1;
                        exeWbBubble = 1'b1;
                        pcWr        = 1'b1;
                        decExeWr    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stallInc = !pcWr || decExeBubble || exeWbBubble;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= BOOT;
            mulCnt   <= '0;
            mulErr   <= 1'b0;
            stallCnt <= '0;
        end else begin
            if (stallInc && (stallCnt != {CNT_W{1'b1}}))
                stallCnt <= stallCnt + CNT_W'(1);
            case (state)
                BOOT:  state <= RUN;
                FLUSH: state <= RUN;
                RUN: begin
                    if (seq.ex_is_mul) begin
                        mulCnt <= '0;
                        state  <= MUL;
                    end else if (seq.ex_jump) begin
                        state <= FLUSH;
                    end
                end
                MUL: begin
                    mulCnt <= mulCnt + MW'(1);
                    if (seq.mul_done) begin
                        state <= RUN;
                    end else if (watchdogHit) begin
                        mulErr <= 1'b1;
                        state  <= RUN;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    // Forwarding and bank write depend only on the buffers, gated to zero in reset
    assign seq.fwd_a          = RST & seq.wb_has_wb & (seq.wb_dest == seq.ex_src_a);
    assign seq.fwd_b          = RST & seq.wb_has_wb & (seq.wb_dest == seq.ex_src_b);
    assign seq.rb_wr          = RST & seq.wb_has_wb;
    assign seq.pc_wr          = pcWr;
    assign seq.pc_sel_jump    = pcSelJump;
    assign seq.dec_exe_wr     = decExeWr;
    assign seq.dec_exe_bubble = decExeBubble;
    assign seq.exe_wb_wr      = exeWbWr;
    assign seq.exe_wb_bubble  = exeWbBubble;
    assign seq.exe_wb_sel_mul = exeWbSelMul;
    assign seq.mul_start      = mulStart;
    assign seq.mul_err        = mulErr;
    assign seq.stall_cnt      = stallCnt;
endmodule
